// File: rtl/snake_pkg.sv
// Shared types for the snake game sequencer: directions, head-cell status codes, scheduler states.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    FREE     = 2'b00,
    FOOD     = 2'b01,
    FREE_ALT = 2'b10,
    HIT      = 2'b11
  } cell_status_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TICK   = 3'd1,
    MOVE   = 3'd2,
    LISTEN = 3'd3,
    OVER   = 3'd4
  } sched_state_t;

endpackage

// File: rtl/snake_move_sched_if.sv
// Move/status handshake between the sequencer (master) and the body/position datapath (slave).
interface snake_move_sched_if
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned SCORE_W = 8
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  dir_t             dir_in;
  cell_status_t     status;
  logic             status_valid;
  logic             move_req;
  dir_t             dir_out;
  logic             is_listening;
  logic             grow;
  logic [LEN_W-1:0] snake_len;
  logic [SCORE_W-1:0] score;
  logic             game_over;
  logic             running;

  modport master (
    input  dir_in, status, status_valid,
    output move_req, dir_out, is_listening, grow, snake_len, score, game_over, running
  );

  modport slave (
    output dir_in, status, status_valid,
    input  move_req, dir_out, is_listening, grow, snake_len, score, game_over, running
  );
endinterface

// File: rtl/snake_tick_timer.sv
// Loadable tick down-counter with zero flag; SNAKE_SPEEDUP_EN shortens the reload as score grows.
module snake_tick_timer #(
  parameter int unsigned TICK_CYCLES = 4,
  parameter int unsigned SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               dec,
  input  logic [SCORE_W-1:0] score,
  output logic               zero_c
);
  localparam int unsigned CNT_W = $clog2(TICK_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] reload_c;

`ifdef SNAKE_SPEEDUP_EN
  logic [SCORE_W-1:0] speed_step_c;
  assign speed_step_c = score >> 2;

  // One cycle shorter per 4 food, never below a reload of 2.
  always_comb begin
    reload_c = CNT_W'(TICK_CYCLES - 1);
    if (32'(speed_step_c) + 32'd3 >= 32'(TICK_CYCLES))
      reload_c = CNT_W'(2);
    else
      reload_c = CNT_W'(32'(TICK_CYCLES - 1) - 32'(speed_step_c));
  end
`else
  logic unused_score;
  assign unused_score = ^score;

  always_comb begin
    reload_c = CNT_W'(TICK_CYCLES - 1);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= reload_c;
    else if (dec)  cnt <= cnt - CNT_W'(1);
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/snake_move_sched.sv
// Snake game sequencer: tick timing, direction commit, move request, status judging, length/score.
// Optional build macro: SNAKE_SPEEDUP_EN (tick period shrinks with score).
module snake_move_sched
  import snake_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 4,
  parameter int unsigned MAX_LEN     = 32,
  parameter int unsigned INIT_LEN    = 3,
  parameter int unsigned SCORE_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_btn,
  snake_move_sched_if.master  bus
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  sched_state_t       state;
  logic               btn_q;
  logic               start_edge_c;
  logic               zero_c;
  logic               load_c;
  logic               dec_c;
  logic [SCORE_W-1:0] reload_score_c;

  // Held-through-reset button reloads btn_q high, so it needs a release before it counts.
  always_ff @(posedge clk) btn_q <= start_btn;
  assign start_edge_c = start_btn & ~btn_q;

  assign load_c = ((state == IDLE || state == OVER) && start_edge_c) ||
                  (state == LISTEN && bus.status_valid && bus.status != HIT);
  assign dec_c  = (state == TICK) && !zero_c;
  assign reload_score_c = (state == OVER) ? '0 : bus.score;

  snake_tick_timer #(
    .TICK_CYCLES (TICK_CYCLES),
    .SCORE_W     (SCORE_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .dec    (dec_c),
    .score  (reload_score_c),
    .zero_c (zero_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      bus.move_req     <= 1'b0;
      bus.dir_out      <= RIGHT;
      bus.is_listening <= 1'b0;
      bus.grow         <= 1'b0;
      bus.snake_len    <= LEN_W'(INIT_LEN);
      bus.score        <= '0;
      bus.game_over    <= 1'b0;
      bus.running      <= 1'b0;
    end else begin
      bus.move_req <= 1'b0;
      bus.grow     <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge_c) begin
            state       <= TICK;
            bus.running <= 1'b1;
          end
        end
        TICK: begin
          if (zero_c) begin
            // A 180-degree reversal would run into the neck; keep heading.
            if (bus.dir_in != dir_t'(bus.dir_out ^ 2'b10))
              bus.dir_out <= bus.dir_in;
            bus.move_req <= 1'b1;
            state        <= MOVE;
          end
        end
        MOVE: begin
          bus.is_listening <= 1'b1;
          state            <= LISTEN;
        end
        LISTEN: begin
          if (bus.status_valid) begin
            bus.is_listening <= 1'b0;
            state            <= TICK;
            if (bus.status == HIT) begin
              bus.game_over <= 1'b1;
              bus.running   <= 1'b0;
              state         <= OVER;
            end else if (bus.status == FOOD) begin
              if (bus.snake_len < LEN_W'(MAX_LEN)) begin
                bus.grow      <= 1'b1;
                bus.snake_len <= bus.snake_len + LEN_W'(1);
              end
              if (bus.score != {SCORE_W{1'b1}})
                bus.score <= bus.score + SCORE_W'(1);
            end
          end
        end
        OVER: begin
          if (start_edge_c) begin
            bus.game_over <= 1'b0;
            bus.snake_len <= LEN_W'(INIT_LEN);
            bus.score     <= '0;
            bus.running   <= 1'b1;
            state         <= TICK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_move_sched.sv
// Directed self-checking bench for snake_move_sched (TICK_CYCLES=4, INIT_LEN=3, MAX_LEN=5).
module tb_snake_move_sched;
  import snake_pkg::*;

  localparam int unsigned TICK_CYCLES = 4;
  localparam int unsigned MAX_LEN     = 5;
  localparam int unsigned INIT_LEN    = 3;
  localparam int unsigned SCORE_W     = 8;

  logic clk = 1'b0;
  logic rst;
  logic start_btn;
  int   tests = 0;
  int   fails = 0;
  int   steps;
  int   moves;

  snake_move_sched_if #(.MAX_LEN(MAX_LEN), .SCORE_W(SCORE_W)) bus ();

  snake_move_sched #(
    .TICK_CYCLES (TICK_CYCLES),
    .MAX_LEN     (MAX_LEN),
    .INIT_LEN    (INIT_LEN),
    .SCORE_W     (SCORE_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_move_req"},  32'(bus.move_req), 32'd0);
    check({tag, "_dir_out"},   32'(bus.dir_out), 32'd1);
    check({tag, "_listening"}, 32'(bus.is_listening), 32'd0);
    check({tag, "_grow"},      32'(bus.grow), 32'd0);
    check({tag, "_len"},       32'(bus.snake_len), 32'd3);
    check({tag, "_score"},     32'(bus.score), 32'd0);
    check({tag, "_game_over"}, 32'(bus.game_over), 32'd0);
    check({tag, "_running"},   32'(bus.running), 32'd0);
  endtask

  // Steps until move_req is seen; n returns the step count, budget-limited.
  task automatic wait_move(input string tag, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (bus.move_req) seen = 1'b1;
    end
    check({tag, "_move_seen"}, 32'(seen), 32'd1);
  endtask

  // Answer the pending move on the second LISTEN cycle (three steps after move_req).
  task automatic respond(input string tag, input cell_status_t s);
    step();
    check({tag, "_req_one_cycle"}, 32'(bus.move_req), 32'd0);
    check({tag, "_listen1"}, 32'(bus.is_listening), 32'd1);
    step();
    check({tag, "_listen2"}, 32'(bus.is_listening), 32'd1);
    bus.status       = s;
    bus.status_valid = 1'b1;
    step();
    bus.status_valid = 1'b0;
    bus.status       = FREE;
    check({tag, "_listen_done"}, 32'(bus.is_listening), 32'd0);
  endtask

  task automatic count_moves(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus.move_req) n++;
    end
  endtask

  initial begin
    rst              = 1'b1;
    start_btn        = 1'b0;
    bus.dir_in       = RIGHT;
    bus.status       = FREE;
    bus.status_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_reset_vals("reset");

    // Idle: no start, stray status pulse must be ignored.
    bus.status = HIT; bus.status_valid = 1'b1;
    step();
    bus.status = FREE; bus.status_valid = 1'b0;
    count_moves(50, moves);
    check("idle_no_move", 32'(moves), 32'd0);
    check("idle_len", 32'(bus.snake_len), 32'd3);
    check("idle_dir", 32'(bus.dir_out), 32'd1);
    check("idle_game_over", 32'(bus.game_over), 32'd0);

    // Start: edge, TICK x4, then MOVE.
    start_btn = 1'b1;
    wait_move("start", steps);
    check("start_latency", 32'(steps), 32'd5);
    check("start_running", 32'(bus.running), 32'd1);

    // Reversal request is rejected.
    bus.dir_in = LEFT;
    respond("free", FREE);
    wait_move("rev", steps);
    check("rev_interval", 32'(steps + 3), 32'd7);
    check("rev_dir", 32'(bus.dir_out), 32'd1);

    // Perpendicular turn is committed.
    bus.dir_in = DOWN;
    respond("free_alt", FREE_ALT);
    wait_move("turn", steps);
    check("turn_interval", 32'(steps + 3), 32'd7);
    check("turn_dir", 32'(bus.dir_out), 32'd2);

    // Food 1: grow, len 4.
    respond("food1", FOOD);
    check("food1_grow", 32'(bus.grow), 32'd1);
    check("food1_len", 32'(bus.snake_len), 32'd4);
    check("food1_score", 32'(bus.score), 32'd1);
    // Stray status during TICK and a start edge while running are both ignored.
    start_btn = 1'b0;
    bus.status = HIT; bus.status_valid = 1'b1;
    step();
    check("food1_grow_pulse", 32'(bus.grow), 32'd0);
    bus.status = FREE; bus.status_valid = 1'b0;
    start_btn = 1'b1;
    wait_move("food1", steps);
    check("food1_interval", 32'(steps + 4), 32'd7);
    check("tick_status_ignored", 32'(bus.game_over), 32'd0);
    check("run_start_ignored", 32'(bus.running), 32'd1);

    respond("food2", FOOD);
    check("food2_grow", 32'(bus.grow), 32'd1);
    check("food2_len", 32'(bus.snake_len), 32'd5);
    check("food2_score", 32'(bus.score), 32'd2);
    wait_move("food2", steps);
    check("food2_interval", 32'(steps + 3), 32'd7);

    respond("food3", FOOD);
    check("food3_grow_sat", 32'(bus.grow), 32'd0);
    check("food3_len_sat", 32'(bus.snake_len), 32'd5);
    check("food3_score", 32'(bus.score), 32'd3);
    wait_move("food3", steps);
    check("food3_interval", 32'(steps + 3), 32'd7);

    // Fourth food: reload still uses score 3, the next one sees score 4.
    respond("food4", FOOD);
    check("food4_score", 32'(bus.score), 32'd4);
    wait_move("food4", steps);
    check("food4_interval", 32'(steps + 3), 32'd7);
    respond("speed", FREE);
    wait_move("speed", steps);
`ifdef SNAKE_SPEEDUP_EN
    check("speed_interval", 32'(steps + 3), 32'd6);
`else
    check("speed_interval", 32'(steps + 3), 32'd7);
`endif

    // Hit coinciding with a start edge: status wins, edge dropped.
    start_btn = 1'b0;
    step();
    step();
    start_btn = 1'b1;
    bus.status = HIT; bus.status_valid = 1'b1;
    step();
    bus.status = FREE; bus.status_valid = 1'b0;
    check("hit_game_over", 32'(bus.game_over), 32'd1);
    check("hit_running", 32'(bus.running), 32'd0);
    count_moves(20, moves);
    check("over_no_move", 32'(moves), 32'd0);
    check("over_edge_dropped", 32'(bus.game_over), 32'd1);
    check("over_len_kept", 32'(bus.snake_len), 32'd5);

    // Restart.
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    step();
    check("restart_game_over", 32'(bus.game_over), 32'd0);
    check("restart_len", 32'(bus.snake_len), 32'd3);
    check("restart_score", 32'(bus.score), 32'd0);
    check("restart_running", 32'(bus.running), 32'd1);
    wait_move("restart", steps);
    check("restart_latency", 32'(steps), 32'd4);

    // Reset during LISTEN with button held: no edge afterwards.
    step();
    check("pre_rst_listen", 32'(bus.is_listening), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_vals("mid_rst");
    bus.status = FOOD; bus.status_valid = 1'b1;
    step();
    bus.status = FREE; bus.status_valid = 1'b0;
    check("post_rst_score", 32'(bus.score), 32'd0);
    check("post_rst_grow", 32'(bus.grow), 32'd0);
    check("post_rst_len", 32'(bus.snake_len), 32'd3);
    count_moves(30, moves);
    check("post_rst_no_move", 32'(moves), 32'd0);
    check("post_rst_running", 32'(bus.running), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
